// File: rtl/apb2axi_cmd_sched.sv
// ---------------------------------------------------------------------------
// apb2axi_cmd_sched
// Picks the next pending directory tag in round-robin order and offers it to
// the AR/AW builder as a single held command. Tracks outstanding read and
// write commands and stops issuing a direction once its limit is reached.
//
// Ports
//   pclk, preset          clock, synchronous active-high reset
//   sched_enable          global issue enable
//   dir_pend_vld          per-tag: allocated, not yet issued
//   dir_pend_is_write     per-tag direction (1 = write)
//   dir_wr_data_rdy       per-tag: write data fully packed
//   sched_issue_vld/tag/is_write   registered command offer
//   sched_issue_rdy       builder accepts the offer
//   sched_issued          one-cycle one-hot pulse of the accepted tag
//   rd_cmpl_vld/wr_cmpl_vld        one command retired
//   rd_outstanding/wr_outstanding  outstanding command counts
//   sched_busy            FSM not in IDLE
//   cnt_err               sticky counter-underflow flag
// ---------------------------------------------------------------------------
module apb2axi_cmd_sched #(
   parameter int unsigned TAG_NUM    = 16,
   parameter int unsigned TAG_W      = $clog2(TAG_NUM),
   parameter int unsigned MAX_RD_OUT = 4,
   parameter int unsigned MAX_WR_OUT = 4,
   localparam int unsigned RD_CW     = $clog2(MAX_RD_OUT + 1),
   localparam int unsigned WR_CW     = $clog2(MAX_WR_OUT + 1)
) (
   input  logic               pclk,
   input  logic               preset,
   input  logic               sched_enable,
   input  logic [TAG_NUM-1:0] dir_pend_vld,
   input  logic [TAG_NUM-1:0] dir_pend_is_write,
   input  logic [TAG_NUM-1:0] dir_wr_data_rdy,
   output logic               sched_issue_vld,
   output logic [TAG_W-1:0]   sched_issue_tag,
   output logic               sched_issue_is_write,
   input  logic               sched_issue_rdy,
   output logic [TAG_NUM-1:0] sched_issued,
   input  logic               rd_cmpl_vld,
   input  logic               wr_cmpl_vld,
   output logic [RD_CW-1:0]   rd_outstanding,
   output logic [WR_CW-1:0]   wr_outstanding,
   output logic               sched_busy,
   output logic               cnt_err
);

   typedef enum logic [1:0] {IDLE, OFFER, SETTLE} state_e;

   localparam logic [RD_CW-1:0] RD_MAX = RD_CW'(MAX_RD_OUT);
   localparam logic [WR_CW-1:0] WR_MAX = WR_CW'(MAX_WR_OUT);

   state_e             state_q, state_d;
   logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               vld_q, vld_d;
   logic               wr_q, wr_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;
   logic [TAG_NUM-1:0] issued_q, issued_d;
   logic [RD_CW-1:0]   rd_cnt_q, rd_cnt_d;
   logic [WR_CW-1:0]   wr_cnt_q, wr_cnt_d;

   logic [TAG_NUM-1:0] elig;
   logic               found;
   logic [TAG_W-1:0]   win;
   logic               hs;
   logic               rd_inc, wr_inc;

   // Per-tag eligibility; counter limits are only consulted here, in IDLE,
   // so with a single open offer a counter can never pass its limit.
   always_comb begin
      elig = '0;
      for (int unsigned t = 0; t < TAG_NUM; t++) begin
         elig[t] = dir_pend_vld[t] & sched_enable &
                   (dir_pend_is_write[t] ? (dir_wr_data_rdy[t] & (wr_cnt_q < WR_MAX))
                                         : (rd_cnt_q < RD_MAX));
      end
   end

   // First eligible tag at or above rr_ptr, wrapping to 0.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int unsigned i = 0; i < TAG_NUM; i++) begin
         if (!found && elig[TAG_W'((32'(rr_ptr_q) + i) % TAG_NUM)]) begin
            found = 1'b1;
            win   = TAG_W'((32'(rr_ptr_q) + i) % TAG_NUM);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      tag_d    = tag_q;
      vld_d    = vld_q;
      wr_d     = wr_q;
      issued_d = '0;
      hs       = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = OFFER;
               tag_d   = win;
               wr_d    = dir_pend_is_write[win];
               vld_d   = 1'b1;
            end
         end
         OFFER: begin
            // Offer is held regardless of pend/enable until accepted.
            if (vld_q && sched_issue_rdy) begin
               hs              = 1'b1;
               vld_d           = 1'b0;
               issued_d[tag_q] = 1'b1;
               rr_ptr_d        = (32'(tag_q) == TAG_NUM - 1) ? '0 : tag_q + TAG_W'(1);
               state_d         = SETTLE;
            end
         end
         SETTLE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_comb begin
      rd_inc   = hs & ~wr_q;
      wr_inc   = hs & wr_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      err_d    = err_q;
      if (rd_inc && !rd_cmpl_vld) begin
         rd_cnt_d = rd_cnt_q + RD_CW'(1);
      end else if (!rd_inc && rd_cmpl_vld) begin
         if (rd_cnt_q == '0) err_d    = 1'b1;
         else                rd_cnt_d = rd_cnt_q - RD_CW'(1);
      end
      if (wr_inc && !wr_cmpl_vld) begin
         wr_cnt_d = wr_cnt_q + WR_CW'(1);
      end else if (!wr_inc && wr_cmpl_vld) begin
         if (wr_cnt_q == '0) err_d    = 1'b1;
         else                wr_cnt_d = wr_cnt_q - WR_CW'(1);
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         tag_q    <= '0;
         vld_q    <= 1'b0;
         wr_q     <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         issued_q <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         tag_q    <= tag_d;
         vld_q    <= vld_d;
         wr_q     <= wr_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         issued_q <= issued_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign sched_issue_vld      = vld_q;
   assign sched_issue_tag      = tag_q;
   assign sched_issue_is_write = wr_q;
   assign sched_issued         = issued_q;
   assign rd_outstanding       = rd_cnt_q;
   assign wr_outstanding       = wr_cnt_q;
   assign sched_busy           = busy_q;
   assign cnt_err              = err_q;

endmodule

// File: tb/tb_apb2axi_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_apb2axi_cmd_sched
// Directed testbench for apb2axi_cmd_sched (TAG_NUM=16, limits 4/4).
// Acts as a simple directory: pending bits clear when sched_issued pulses.
// Handshakes and issued pulses are logged and compared to hand-derived values.
// ---------------------------------------------------------------------------
module tb_apb2axi_cmd_sched;

   logic        pclk = 1'b0;
   logic        preset;
   logic        sched_enable;
   logic [15:0] dir_pend_vld;
   logic [15:0] dir_pend_is_write;
   logic [15:0] dir_wr_data_rdy;
   logic        sched_issue_vld;
   logic [3:0]  sched_issue_tag;
   logic        sched_issue_is_write;
   logic        sched_issue_rdy;
   logic [15:0] sched_issued;
   logic        rd_cmpl_vld;
   logic        wr_cmpl_vld;
   logic [2:0]  rd_outstanding;
   logic [2:0]  wr_outstanding;
   logic        sched_busy;
   logic        cnt_err;

   apb2axi_cmd_sched #(
      .TAG_NUM    (16),
      .TAG_W      (4),
      .MAX_RD_OUT (4),
      .MAX_WR_OUT (4)
   ) dut (
      .pclk                 (pclk),
      .preset               (preset),
      .sched_enable         (sched_enable),
      .dir_pend_vld         (dir_pend_vld),
      .dir_pend_is_write    (dir_pend_is_write),
      .dir_wr_data_rdy      (dir_wr_data_rdy),
      .sched_issue_vld      (sched_issue_vld),
      .sched_issue_tag      (sched_issue_tag),
      .sched_issue_is_write (sched_issue_is_write),
      .sched_issue_rdy      (sched_issue_rdy),
      .sched_issued         (sched_issued),
      .rd_cmpl_vld          (rd_cmpl_vld),
      .wr_cmpl_vld          (wr_cmpl_vld),
      .rd_outstanding       (rd_outstanding),
      .wr_outstanding       (wr_outstanding),
      .sched_busy           (sched_busy),
      .cnt_err              (cnt_err)
   );

   always #5 pclk = ~pclk;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned cyc    = 0;

   int          hs_tag[$];
   int          hs_cyc[$];
   bit          hs_wr[$];
   logic [15:0] iss[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else             n_pass++;
   endtask

   // One clock: log a handshake seen before the edge, then sample #1 after it.
   task automatic step();
      if (sched_issue_vld === 1'b1 && sched_issue_rdy === 1'b1) begin
         hs_tag.push_back(int'(sched_issue_tag));
         hs_wr.push_back(sched_issue_is_write);
         hs_cyc.push_back(int'(cyc));
      end
      @(posedge pclk);
      #1;
      cyc++;
      if (sched_issued != '0) begin
         iss.push_back(sched_issued);
         dir_pend_vld = dir_pend_vld & ~sched_issued;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_log();
      hs_tag.delete();
      hs_cyc.delete();
      hs_wr.delete();
      iss.delete();
   endtask

   task automatic rd_cmpl(input int n);
      rd_cmpl_vld = 1'b1;
      run(n);
      rd_cmpl_vld = 1'b0;
   endtask

   initial begin
      preset            = 1'b1;
      sched_enable      = 1'b0;
      dir_pend_vld      = '0;
      dir_pend_is_write = '0;
      dir_wr_data_rdy   = '0;
      sched_issue_rdy   = 1'b0;
      rd_cmpl_vld       = 1'b0;
      wr_cmpl_vld       = 1'b0;
      run(2);
      preset = 1'b0;

      // Reset state
      check("rst_vld",    32'(sched_issue_vld), 0);
      check("rst_tag",    32'(sched_issue_tag), 0);
      check("rst_wr",     32'(sched_issue_is_write), 0);
      check("rst_issued", 32'(sched_issued), 0);
      check("rst_rd",     32'(rd_outstanding), 0);
      check("rst_wrcnt",  32'(wr_outstanding), 0);
      check("rst_busy",   32'(sched_busy), 0);
      check("rst_err",    32'(cnt_err), 0);

      // Idle with nothing pending stays idle
      sched_enable    = 1'b1;
      sched_issue_rdy = 1'b1;
      run(3);
      check("idle_vld",  32'(sched_issue_vld), 0);
      check("idle_busy", 32'(sched_busy), 0);

      // Round-robin 3, 7, 12
      clear_log();
      dir_pend_vld = 16'h1088;
      step();
      check("rr_first_vld",  32'(sched_issue_vld), 1);
      check("rr_first_tag",  32'(sched_issue_tag), 3);
      check("rr_first_busy", 32'(sched_busy), 1);
      run(10);
      check("rr_hs_n",    32'(hs_tag.size()), 3);
      check("rr_hs0",     32'(hs_tag[0]), 3);
      check("rr_hs1",     32'(hs_tag[1]), 7);
      check("rr_hs2",     32'(hs_tag[2]), 12);
      check("rr_gap01",   32'(hs_cyc[1] - hs_cyc[0]), 3);
      check("rr_gap12",   32'(hs_cyc[2] - hs_cyc[1]), 3);
      check("rr_iss0",    32'(iss[0]), 32'h0008);
      check("rr_iss1",    32'(iss[1]), 32'h0080);
      check("rr_iss2",    32'(iss[2]), 32'h1000);
      check("rr_rd",      32'(rd_outstanding), 3);
      check("rr_busy_end", 32'(sched_busy), 0);
      rd_cmpl(3);
      check("rr_drain", 32'(rd_outstanding), 0);

      // Wrap: issue 14, then 2 and 15 pending -> 15 then 2
      dir_pend_vld = 16'h4000;
      run(6);
      rd_cmpl(1);
      clear_log();
      dir_pend_vld = 16'h8004;
      run(10);
      check("wrap_n",   32'(hs_tag.size()), 2);
      check("wrap_hs0", 32'(hs_tag[0]), 15);
      check("wrap_hs1", 32'(hs_tag[1]), 2);
      rd_cmpl(2);
      check("wrap_drain", 32'(rd_outstanding), 0);

      // Backpressure on tag 5; pend and enable drop while held
      sched_issue_rdy = 1'b0;
      dir_pend_vld    = 16'h0020;
      step();
      dir_pend_vld = '0;
      sched_enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("bp_vld",    32'(sched_issue_vld), 1);
         check("bp_tag",    32'(sched_issue_tag), 5);
         check("bp_issued", 32'(sched_issued), 0);
         if (i < 5) step();
      end
      clear_log();
      sched_issue_rdy = 1'b1;
      step();
      check("bp_pulse",   32'(sched_issued), 32'h0020);
      check("bp_vld_off", 32'(sched_issue_vld), 0);
      check("bp_rd",      32'(rd_outstanding), 1);
      step();
      check("bp_pulse_end", 32'(sched_issued), 0);
      sched_enable = 1'b1;
      rd_cmpl(1);

      // Read limit: five reads from rr_ptr=6, no completions
      clear_log();
      dir_pend_vld = 16'h2F00;
      run(25);
      check("lim_n",   32'(hs_tag.size()), 4);
      check("lim_hs3", 32'(hs_tag[3]), 11);
      check("lim_rd",  32'(rd_outstanding), 4);
      check("lim_vld", 32'(sched_issue_vld), 0);
      rd_cmpl(1);
      run(8);
      check("lim5_n",   32'(hs_tag.size()), 5);
      check("lim5_hs4", 32'(hs_tag[4]), 13);
      check("lim5_rd",  32'(rd_outstanding), 4);

      // Handshake coincident with completion leaves count unchanged
      rd_cmpl(1);
      check("coin_pre", 32'(rd_outstanding), 3);
      dir_pend_vld = 16'h0001;
      step();
      check("coin_tag", 32'(sched_issue_tag), 0);
      rd_cmpl_vld = 1'b1;
      step();
      rd_cmpl_vld = 1'b0;
      check("coin_pulse", 32'(sched_issued), 32'h0001);
      check("coin_rd",    32'(rd_outstanding), 3);
      rd_cmpl(3);
      check("coin_drain", 32'(rd_outstanding), 0);

      // Write gating: tag 1 write without data, tag 4 read
      clear_log();
      dir_pend_is_write = 16'h0002;
      dir_wr_data_rdy   = 16'h0000;
      dir_pend_vld      = 16'h0012;
      run(6);
      check("wg_n",     32'(hs_tag.size()), 1);
      check("wg_hs0",   32'(hs_tag[0]), 4);
      check("wg_dir0",  32'(hs_wr[0]), 0);
      check("wg_wrcnt", 32'(wr_outstanding), 0);
      dir_wr_data_rdy = 16'h0002;
      step();
      check("wg_vld", 32'(sched_issue_vld), 1);
      check("wg_tag", 32'(sched_issue_tag), 1);
      check("wg_wr",  32'(sched_issue_is_write), 1);
      step();
      check("wg_pulse",  32'(sched_issued), 32'h0002);
      check("wg_wrcnt1", 32'(wr_outstanding), 1);
      check("wg_rd1",    32'(rd_outstanding), 1);
      dir_pend_is_write = '0;
      dir_wr_data_rdy   = '0;
      rd_cmpl_vld = 1'b1;
      wr_cmpl_vld = 1'b1;
      step();
      rd_cmpl_vld = 1'b0;
      wr_cmpl_vld = 1'b0;
      check("wg_rd_drain", 32'(rd_outstanding), 0);
      check("wg_wr_drain", 32'(wr_outstanding), 0);
      check("wg_err",      32'(cnt_err), 0);

      // Underflow sets sticky error
      wr_cmpl_vld = 1'b1;
      step();
      wr_cmpl_vld = 1'b0;
      check("uf_err",   32'(cnt_err), 1);
      check("uf_wrcnt", 32'(wr_outstanding), 0);
      step();
      check("uf_sticky", 32'(cnt_err), 1);

      // Reset mid-OFFER drops the offer and clears the error
      sched_issue_rdy = 1'b0;
      dir_pend_vld    = 16'h0040;
      step();
      check("ro_vld", 32'(sched_issue_vld), 1);
      check("ro_tag", 32'(sched_issue_tag), 6);
      preset = 1'b1;
      step();
      preset = 1'b0;
      check("ro_vld_off", 32'(sched_issue_vld), 0);
      check("ro_tag0",    32'(sched_issue_tag), 0);
      check("ro_err",     32'(cnt_err), 0);
      check("ro_busy",    32'(sched_busy), 0);
      check("ro_issued",  32'(sched_issued), 0);
      dir_pend_vld = '0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
